// File: rtl/regfile_core.sv
// ============================================================================
// regfile_core : 32 x WIDTH register file, one-hot write, two one-hot OR reads.
// Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [31:0]      wr_sel,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [31:0]      rd_selA,
  input  logic [31:0]      rd_selB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic             wr_sel_err
);

  logic             wr_any;
  logic             wr_onehot;
  logic             wr_multi;
  logic [31:0]      wr_en;
  logic             err_q;
  logic             err_d;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // x & (x-1) clears the lowest set bit; anything left means popcount >= 2.
  assign wr_any    = |wr_sel;
  assign wr_onehot = wr_any && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
  assign wr_multi  = wr_any && !wr_onehot;
  assign wr_en     = wr_onehot ? wr_sel : 32'd0;

  assign err_d = err_q | wr_multi;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wr_sel_err = err_q;

  generate
    for (genvar i = 0; i < 32; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign regs_q[i] = '0;
      end else begin : g_ff
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] d;

        assign d = wr_en[i] ? data_writeReg : q;

        always_ff @(posedge clock or posedge ctrl_reset) begin
          if (ctrl_reset) begin
            q <= '0;
          end else begin
            q <= d;
          end
        end

        assign regs_q[i] = q;
      end
    end
  endgenerate

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < 32; i++) begin
      stored_a = stored_a | ({WIDTH{rd_selA[i]}} & regs_q[i]);
      stored_b = stored_b | ({WIDTH{rd_selB[i]}} & regs_q[i]);
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;

  assign fwd_ok = wr_onehot && !wr_sel[0] && !ctrl_reset;

  always_comb begin
    data_readRegA = stored_a;
    data_readRegB = stored_b;
    if (fwd_ok && (rd_selA == wr_sel)) begin
      data_readRegA = data_writeReg;
    end
    if (fwd_ok && (rd_selB == wr_sel)) begin
      data_readRegB = data_writeReg;
    end
  end
`else
  assign data_readRegA = stored_a;
  assign data_readRegB = stored_b;
`endif

endmodule

`default_nettype wire
